// File: rtl/memory_4_port_rr_responder_pkg.sv
// memory_4_port_rr_responder_pkg: shared client count and round-robin pick function
package memory_4_port_rr_responder_pkg;
  localparam int NUM_CLIENTS = 4;
  // Iterate from farthest to nearest so the first valid client after ptr wins.
  function automatic logic [3:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/memory_4_port_rr_responder_mem.sv
// single_port_mem: single-port RAM with a registered read port, read-before-write
module single_port_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 56,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= mem[addr];
  end
endmodule

// File: rtl/memory_4_port_rr_responder.sv
// memory_4_port_rr_responder: round-robin arbiter mapping four clients onto windows of one RAM
module memory_4_port_rr_responder
  import memory_4_port_rr_responder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SINGLE_MEM_DEPTH = 14,
  parameter int FULL_MEM_DEPTH = NUM_CLIENTS * SINGLE_MEM_DEPTH,
  parameter int SML = $clog2(SINGLE_MEM_DEPTH),
  parameter int FML = $clog2(FULL_MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req_valid,
  input  logic [3:0]             req_we,
  input  logic [4*SML-1:0]       req_addr,
  input  logic [4*WIDTH-1:0]     req_din,
  output logic [3:0]             req_ready,
  output logic [3:0]             rsp_valid,
  output logic [WIDTH-1:0]       rsp_dout,
  output logic [3:0]             addr_err
);
  logic [1:0] rr_ptr_q, rr_ptr_d, rd_owner_q, rd_owner_d, win;
  logic rd_pend_q, rd_pend_d, rd_zero_q, rd_zero_d;
  logic [3:0] addr_err_q, addr_err_d, grant;
  logic [SML-1:0] sel_addr;
  logic [WIDTH-1:0] sel_din, ram_q;
  logic [FML-1:0] ram_addr;
  logic sel_we, in_range, any, ram_we;
  always_comb begin
    grant = rr_pick(req_valid, rr_ptr_q);
    any = |grant;
    win = {grant[3] | grant[2], grant[3] | grant[1]};
    sel_addr = req_addr[win*SML +: SML];
    sel_din = req_din[win*WIDTH +: WIDTH];
    sel_we = req_we[win];
    in_range = 32'(sel_addr) < 32'(SINGLE_MEM_DEPTH);
    ram_addr = FML'(sel_addr) + FML'(win) * FML'(SINGLE_MEM_DEPTH);
    ram_we = any & sel_we & in_range;
    rr_ptr_d = any ? win : rr_ptr_q;
    rd_pend_d = any & ~sel_we;
    rd_owner_d = win;
    rd_zero_d = ~in_range;
    addr_err_d = addr_err_q | (grant & {4{~in_range}});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 2'd3;
      rd_pend_q <= 1'b0;
      rd_owner_q <= 2'd0;
      rd_zero_q <= 1'b0;
      addr_err_q <= 4'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_zero_q <= rd_zero_d;
      addr_err_q <= addr_err_d;
    end
  end
  single_port_mem #(.WIDTH(WIDTH), .DEPTH(FULL_MEM_DEPTH), .AW(FML)) u_mem (
    .clk(clk), .we(ram_we), .addr(ram_addr), .din(sel_din), .q(ram_q)
  );
  always_comb begin
    req_ready = grant;
    rsp_valid = rd_pend_q ? 4'b0001 << rd_owner_q : 4'b0000;
    rsp_dout = rd_zero_q ? '0 : ram_q;
    addr_err = addr_err_q;
  end
endmodule

// File: tb/tb_memory_4_port_rr_responder.sv
// tb_memory_4_port_rr_responder: directed vector bench for the round-robin memory responder
module tb_memory_4_port_rr_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid, req_we, req_ready, rsp_valid, addr_err;
  logic [15:0] req_addr;
  logic [127:0] req_din;
  logic [31:0] rsp_dout;
  int checks = 0, failures = 0;
  typedef struct { logic [3:0] valid; logic [3:0] ready; } vec_t;
  vec_t vecs[16];
  memory_4_port_rr_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic req(input int c, input logic we, input logic [3:0] a, input logic [31:0] d);
    req_valid[c] = 1'b1;
    req_we[c] = we;
    req_addr[c*4 +: 4] = a;
    req_din[c*32 +: 32] = d;
  endtask
  // Called just after a negedge with inputs set; returns at the following negedge.
  task automatic step(input string name, input logic [3:0] er, input logic [3:0] ev);
    #1 chk({name, "_ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    #1 chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'(ev));
    @(negedge clk);
  endtask
  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_din = '0;
    #1 chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) vecs[i] = '{4'hF, 4'b0001 << (i % 4)};
    vecs[8] = '{4'hD, 4'b0001}; vecs[9] = '{4'hD, 4'b0100};
    vecs[10] = '{4'hD, 4'b1000}; vecs[11] = '{4'hD, 4'b0001};
    vecs[12] = '{4'h0, 4'b0000}; vecs[13] = '{4'h2, 4'b0010};
    vecs[14] = '{4'h2, 4'b0010}; vecs[15] = '{4'h8, 4'b1000};
    for (int i = 0; i < 16; i++) begin
      req_valid = vecs[i].valid;
      step($sformatf("vec%0d", i), vecs[i].ready, vecs[i].ready);
    end
    req_valid = '0; req(2, 1'b1, 4'd5, 32'hDEAD_0002);
    step("win_wr", 4'b0100, 4'b0000);
    req_valid = '0; req(0, 1'b1, 4'd5, 32'h1111_0000);
    step("c0_wr", 4'b0001, 4'b0000);
    req_valid = '0; req(2, 1'b0, 4'd5, 32'h0);
    step("win_rd", 4'b0100, 4'b0100);
    chk("win_rd_dout", rsp_dout, 32'hDEAD_0002);
    req_valid = '0; req(0, 1'b0, 4'd5, 32'h0);
    step("c0_rd", 4'b0001, 4'b0001);
    chk("c0_rd_dout", rsp_dout, 32'h1111_0000);
    req_valid = '0; req(1, 1'b1, 4'd3, 32'hB1B1_0003);
    step("c1_wr", 4'b0010, 4'b0000);
    req_valid = '0; req(0, 1'b1, 4'd3, 32'hA0A0_0003); req(1, 1'b0, 4'd3, 32'h0);
    step("cc_a", 4'b0001, 4'b0000);
    req_valid[0] = 1'b0;
    step("cc_b", 4'b0010, 4'b0010);
    chk("cc_b_dout", rsp_dout, 32'hB1B1_0003);
    req_valid = '0; req(0, 1'b0, 4'd3, 32'h0);
    step("cc_c0", 4'b0001, 4'b0001);
    chk("cc_c0_dout", rsp_dout, 32'hA0A0_0003);
    for (int a = 0; a < 14; a++) begin
      req_valid = '0; req(3, 1'b1, 4'(a), 32'h3300_0000 | 32'(a));
      step($sformatf("c3_fill%0d", a), 4'b1000, 4'b0000);
    end
    chk("pre_oor_err", 32'(addr_err), 0);
    req_valid = '0; req(3, 1'b0, 4'd14, 32'h0);
    step("oor_rd", 4'b1000, 4'b1000);
    chk("oor_rd_dout", rsp_dout, 0);
    chk("oor_err", 32'(addr_err), 32'h8);
    req_valid = '0; req(3, 1'b1, 4'd15, 32'hFFFF_FFFF);
    step("oor_wr", 4'b1000, 4'b0000);
    for (int a = 0; a < 14; a++) begin
      req_valid = '0; req(3, 1'b0, 4'(a), 32'h0);
      step($sformatf("c3_chk%0d", a), 4'b1000, 4'b1000);
      chk($sformatf("c3_dout%0d", a), rsp_dout, 32'h3300_0000 | 32'(a));
    end
    chk("err_sticky", 32'(addr_err), 32'h8);
    req_valid = '0; req(1, 1'b0, 4'd3, 32'h0);
    #1 chk("mid_ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 chk("mid_rsp_pre", 32'(rsp_valid), 32'h2);
    #2 rst = 1'b1;
    #1 chk("mid_rst_rsp", 32'(rsp_valid), 0);
    chk("mid_rst_err", 32'(addr_err), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0; req_valid = 4'hF; req_we = '0; req_addr = '0;
    step("post_rst", 4'b0001, 4'b0001);
    req_valid = '0; req(2, 1'b0, 4'd5, 32'h0);
    #1 chk("fl_ready", 32'(req_ready), 32'h4);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("fl_rsp0", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    step("fl_idle", 4'b0000, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
